// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared widths, event field offsets and channel ids for the TDC event packer
package tdc_pkg;

    localparam int TDC_COARSE_W = 32;
    localparam int TDC_FINE_W   = 8;
    localparam int EVT_W        = 2 + TDC_COARSE_W + TDC_FINE_W;

    localparam int FINE_LSB     = 0;
    localparam int COARSE_LSB   = TDC_FINE_W;
    localparam int CHAN_BIT     = TDC_FINE_W + TDC_COARSE_W;
    localparam int LOST_BIT     = CHAN_BIT + 1;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } tdc_chan_e;

endpackage

// File: rtl/tdc_sync_fifo.sv
// rtl/tdc_sync_fifo.sv - single-clock show-ahead FIFO with extra-MSB pointers for full/empty
module tdc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign level_o = r_wr_ptr - r_rd_ptr;

    // Full is judged before any same-cycle pop, so a full FIFO never takes a write.
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
        end
    end

    // Storage is not reset; gating the head keeps the output at zero whenever empty.
    assign head_data_o = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/tdc_event_packer.sv
// rtl/tdc_event_packer.sv - tags two TDC channels, holds one event each, round-robins them into a FIFO
module tdc_event_packer
    import tdc_pkg::*;
#(
    parameter int COARSE_W = TDC_COARSE_W,
    parameter int FINE_W   = TDC_FINE_W,
    parameter int DEPTH    = 16,
    parameter int DROP_W   = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [1:0]                     ch_valid_i,
    input  logic [COARSE_W-1:0]            ch0_coarse_i,
    input  logic [FINE_W-1:0]              ch0_fine_i,
    input  logic [COARSE_W-1:0]            ch1_coarse_i,
    input  logic [FINE_W-1:0]              ch1_fine_i,
    output logic                           evt_valid_o,
    input  logic                           evt_ready_i,
    output logic [2+COARSE_W+FINE_W-1:0]   evt_data_o,
    output logic [$clog2(DEPTH):0]         fifo_level_o,
    output logic [DROP_W-1:0]              drop_cnt0_o,
    output logic [DROP_W-1:0]              drop_cnt1_o
);

    localparam int L_EVT_W = 2 + COARSE_W + FINE_W;

    logic [1:0]          r_hold_full;
    logic [1:0]          r_lost;
    logic [COARSE_W-1:0] r_coarse [2];
    logic [FINE_W-1:0]   r_fine   [2];
    logic [DROP_W-1:0]   r_drop   [2];
    tdc_chan_e           r_rr;

    tdc_chan_e           w_gnt;
    logic                w_gnt_idx;
    logic                w_wr_en;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic [1:0]          w_drain;
    logic [1:0]          w_capture;
    logic [1:0]          w_drop;
    logic [COARSE_W-1:0] w_in_coarse [2];
    logic [FINE_W-1:0]   w_in_fine   [2];
    logic [L_EVT_W-1:0]  w_wr_word;

    assign w_in_coarse[0] = ch0_coarse_i;
    assign w_in_coarse[1] = ch1_coarse_i;
    assign w_in_fine[0]   = ch0_fine_i;
    assign w_in_fine[1]   = ch1_fine_i;

    // The pointer only matters when both holds compete; a lone full hold always wins.
    always_comb begin
        w_gnt = r_rr;
        if (r_hold_full == 2'b01) begin
            w_gnt = CH0;
        end else if (r_hold_full == 2'b10) begin
            w_gnt = CH1;
        end
    end

    assign w_gnt_idx = w_gnt;
    assign w_wr_en   = (|r_hold_full) && !w_fifo_full;

    always_comb begin
        w_drain   = '0;
        w_capture = '0;
        w_drop    = '0;
        for (int n = 0; n < 2; n++) begin
            w_drain[n]   = w_wr_en && (w_gnt_idx == n[0]);
            w_capture[n] = ch_valid_i[n] && (!r_hold_full[n] || w_drain[n]);
            w_drop[n]    = ch_valid_i[n] && r_hold_full[n] && !w_drain[n];
        end
    end

    assign w_wr_word = {r_lost[w_gnt_idx], w_gnt_idx, r_coarse[w_gnt_idx], r_fine[w_gnt_idx]};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hold_full <= '0;
            r_lost      <= '0;
            r_rr        <= CH0;
            for (int n = 0; n < 2; n++) begin
                r_coarse[n] <= '0;
                r_fine[n]   <= '0;
                r_drop[n]   <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_rr <= (w_gnt == CH0) ? CH1 : CH0;
            end
            for (int n = 0; n < 2; n++) begin
                if (w_capture[n]) begin
                    r_hold_full[n] <= 1'b1;
                    r_coarse[n]    <= w_in_coarse[n];
                    r_fine[n]      <= w_in_fine[n];
                end else if (w_drain[n]) begin
                    r_hold_full[n] <= 1'b0;
                end
                // A drop landing on the grant cycle keeps lost set for the next word.
                if (w_drop[n]) begin
                    r_lost[n] <= 1'b1;
                    if (r_drop[n] != {DROP_W{1'b1}}) begin
                        r_drop[n] <= r_drop[n] + 1'b1;
                    end
                end else if (w_drain[n]) begin
                    r_lost[n] <= 1'b0;
                end
            end
        end
    end

    assign evt_valid_o = !w_fifo_empty;
    assign w_pop       = evt_valid_o && evt_ready_i;
    assign drop_cnt0_o = r_drop[0];
    assign drop_cnt1_o = r_drop[1];

    tdc_sync_fifo #(
        .WIDTH (L_EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .push_i      (w_wr_en),
        .push_data_i (w_wr_word),
        .pop_i       (w_pop),
        .head_data_o (evt_data_o),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .level_o     (fifo_level_o)
    );

endmodule

// File: tb/tb_tdc_event_packer.sv
// tb/tb_tdc_event_packer.sv - directed checks of the TDC event packer
module tb_tdc_event_packer;
    import tdc_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       ch_valid;
    logic [31:0]      ch0_coarse;
    logic [7:0]       ch0_fine;
    logic [31:0]      ch1_coarse;
    logic [7:0]       ch1_fine;
    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_data;
    logic [4:0]       level;
    logic [3:0]       drop0;
    logic [3:0]       drop1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdc_event_packer #(
        .COARSE_W (32),
        .FINE_W   (8),
        .DEPTH    (16),
        .DROP_W   (4)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .ch_valid_i   (ch_valid),
        .ch0_coarse_i (ch0_coarse),
        .ch0_fine_i   (ch0_fine),
        .ch1_coarse_i (ch1_coarse),
        .ch1_fine_i   (ch1_fine),
        .evt_valid_o  (evt_valid),
        .evt_ready_i  (evt_ready),
        .evt_data_o   (evt_data),
        .fifo_level_o (level),
        .drop_cnt0_o  (drop0),
        .drop_cnt1_o  (drop1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [EVT_W-1:0] word(input logic lost, input logic ch,
                                              input logic [31:0] c, input logic [7:0] f);
        return {lost, ch, c, f};
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        ch_valid  = 2'b00;
        evt_ready = 1'b0;
        step(2);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_data", evt_data, '0);
        chk("rst_level", level, 5'd0);
        chk("rst_drop0", drop0, 4'd0);
        chk("rst_drop1", drop1, 4'd0);
        reset_n = 1'b1;
        step(1);
    endtask

    // Output monitor: head must hold while stalled; each channel's coarse must rise.
    logic             mon_en = 1'b0;
    logic             prev_stall = 1'b0;
    logic [EVT_W-1:0] prev_data;
    logic [31:0]      last_c [2];
    logic             mon_ch;
    int               n_acc = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("hold_stable", evt_data, prev_data);
            end
            if (evt_valid && evt_ready) begin
                mon_ch = evt_data[CHAN_BIT];
                chk("mono", evt_data[COARSE_LSB +: 32] > last_c[mon_ch], 1'b1);
                last_c[mon_ch] = evt_data[COARSE_LSB +: 32];
                n_acc++;
            end
            prev_stall = evt_valid && !evt_ready;
            prev_data  = evt_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int c0;
        int c1;
        ch0_coarse = '0;
        ch0_fine   = '0;
        ch1_coarse = '0;
        ch1_fine   = '0;
        do_reset();

        // single event, two-cycle latency
        ch_valid = 2'b01; ch0_coarse = 32'h0000_1234; ch0_fine = 8'h5A; evt_ready = 1'b1;
        step();
        ch_valid = 2'b00;
        chk("single_lat1", evt_valid, 1'b0);
        step();
        chk("single_valid", evt_valid, 1'b1);
        chk("single_data", evt_data, word(1'b0, 1'b0, 32'h0000_1234, 8'h5A));
        chk("single_level", level, 5'd1);
        step();
        chk("single_done", evt_valid, 1'b0);
        chk("single_lvl0", level, 5'd0);

        // simultaneous, pointer at ch0
        do_reset();
        evt_ready = 1'b1;
        ch_valid = 2'b11; ch0_coarse = 32'd10; ch0_fine = 8'h01; ch1_coarse = 32'd20; ch1_fine = 8'h02;
        step();
        ch_valid = 2'b00;
        step();
        chk("rr0_first", evt_data, word(1'b0, 1'b0, 32'd10, 8'h01));
        step();
        chk("rr0_second_v", evt_valid, 1'b1);
        chk("rr0_second", evt_data, word(1'b0, 1'b1, 32'd20, 8'h02));
        step();
        chk("rr0_empty", evt_valid, 1'b0);

        // one ch0 grant moves the pointer to ch1, then simultaneous again
        ch_valid = 2'b01; ch0_coarse = 32'd5; ch0_fine = 8'h00;
        step();
        ch_valid = 2'b00;
        step(3);
        ch_valid = 2'b11; ch0_coarse = 32'd30; ch0_fine = 8'h03; ch1_coarse = 32'd40; ch1_fine = 8'h04;
        step();
        ch_valid = 2'b00;
        step();
        chk("rr1_first", evt_data, word(1'b0, 1'b1, 32'd40, 8'h04));
        step();
        chk("rr1_second", evt_data, word(1'b0, 1'b0, 32'd30, 8'h03));
        step();

        // back-pressure fill on ch0
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            ch_valid = 2'b01; ch0_coarse = k; ch0_fine = k[7:0];
            step();
        end
        ch_valid = 2'b00;
        step(2);
        chk("bp_level", level, 5'd16);
        chk("bp_drop0", drop0, 4'd3);
        chk("bp_drop1", drop1, 4'd0);
        evt_ready = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            chk("bp_word", evt_data, word(k == 17, 1'b0, k, k[7:0]));
            step();
        end
        chk("bp_drained", evt_valid, 1'b0);
        chk("bp_lvl0", level, 5'd0);

        // random ready with an interleaved stream
        do_reset();
        last_c[0] = '0;
        last_c[1] = '0;
        c0 = 0;
        c1 = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 160; i++) begin
            ch_valid = 2'b00;
            if (i % 4 == 0) begin
                c0++; ch_valid = 2'b01; ch0_coarse = c0; ch0_fine = c0[7:0];
            end else if (i % 4 == 2) begin
                c1++; ch_valid = 2'b10; ch1_coarse = c1; ch1_fine = c1[7:0];
            end
            evt_ready = 1'($urandom_range(0, 1));
            step();
        end
        ch_valid = 2'b00;
        evt_ready = 1'b1;
        step(40);
        mon_en = 1'b0;
        chk("rand_lvl0", level, 5'd0);
        chk("rand_accepted", n_acc > 0, 1'b1);

        // drop counter saturation on ch1
        do_reset();
        for (int k = 1; k <= 57; k++) begin
            ch_valid = 2'b10; ch1_coarse = k; ch1_fine = k[7:0];
            step();
            if (k == 22) begin
                chk("sat_mid", drop1, 4'd5);
            end
        end
        ch_valid = 2'b00;
        step();
        chk("sat_drop1", drop1, 4'd15);
        chk("sat_drop0", drop0, 4'd0);
        chk("sat_level", level, 5'd16);

        // async reset mid-stream at level 7
        do_reset();
        ch_valid = 2'b11; ch0_coarse = 32'd1; ch1_coarse = 32'd2; ch0_fine = 8'h0; ch1_fine = 8'h0;
        step();
        ch_valid = 2'b11; ch0_coarse = 32'd3; ch1_coarse = 32'd4;
        step();
        ch_valid = 2'b00;
        step(3);
        for (int k = 0; k < 4; k++) begin
            ch_valid = 2'b01; ch0_coarse = 32'd10 + k;
            step();
        end
        ch_valid = 2'b00;
        step(3);
        chk("ar_level7", level, 5'd7);
        chk("ar_drop1_pre", drop1, 4'd1);
        reset_n = 1'b0;
        #2;
        chk("ar_valid", evt_valid, 1'b0);
        chk("ar_level", level, 5'd0);
        chk("ar_data", evt_data, '0);
        chk("ar_drop1", drop1, 4'd0);
        chk("ar_drop0", drop0, 4'd0);
        step();
        reset_n = 1'b1;
        step();
        ch_valid = 2'b01; ch0_coarse = 32'h0000_ABCD; ch0_fine = 8'h11; evt_ready = 1'b1;
        step();
        ch_valid = 2'b00;
        chk("ar_lat1", evt_valid, 1'b0);
        step();
        chk("ar_lat2", evt_valid, 1'b1);
        chk("ar_word", evt_data, word(1'b0, 1'b0, 32'h0000_ABCD, 8'h11));
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
